uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  Receive half of my_uart: consumes the 16x-baud enable tick from the RX divisor counter, deserialises 8N1 frames on rxd and holds one byte for the CPU bus.
//  Validates start bits, majority-votes each bit and flags framing and overrun errors.
//  Sits between the pad (rxd) and the UART register block.
// PARAMETERS
//  DATA_BITS   8    data bits per frame, LSB first (range 5..8)
//  OVERSAMPLE  16   en_rx ticks per bit period (fixed; counters sized 4 bits)
// PORTS
//  clk        in   1          UART clock
//  rst        in   1          reset, asynchronous, active-high
//  en_rx      in   1          1-clk pulse at 16x baud from divisor counter
//  rxd        in   1          serial input, asynchronous, idle high
//  rd         in   1          1-clk strobe: CPU has read data
//  data       out  DATA_BITS  last received byte
//  ready      out  1          data holds unread byte
//  frame_err  out  1          stop bit of byte in data sampled low
//  overrun    out  1          byte completed while ready was 1
//  busy       out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset: data=0, ready=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, sync regs=1, counters=0.
//  rxd passes through 2-FF synchroniser -> rxd_s; all decisions use rxd_s only.
//  State advance, counters and sampling occur only on clk edges with en_rx=1; else hold.
//  tick_cnt 0..15 within bit; majority vote of rxd_s at tick_cnt 7,8,9, decided at 9.
//  FSM:
//   IDLE : en_rx & rxd_s==0 -> START, tick_cnt=0.
//   START: at tick 9 vote==1 -> IDLE (glitch, no flags); vote==0 -> continue;
//          at tick 15 -> DATA, bit_cnt=0, tick_cnt=0.
//   DATA : at tick 9 shift vote into shreg (LSB first); at tick 15 bit_cnt++;
//          after DATA_BITS bits -> STOP.
//   STOP : at tick 9 commit: data<=shreg, ready<=1, frame_err<=~vote,
//          overrun<=ready_old (sticky, set if unread byte overwritten);
//          vote==1 -> IDLE; vote==0 -> BRK.
//   BRK  : wait until rxd_s==1 (en_rx qualified) -> IDLE; no new frame while low.
//  Commit is at mid-stop-bit, so back-to-back frames with 1 stop bit are accepted.
//  Latency: ready rises clk after the en_rx edge that is tick 9 of stop bit.
//  rd: clears ready and overrun next clk; frame_err and data unchanged.
//  rd coincident with commit: commit wins; ready=1, overrun not set, new byte in data.
//  rd when ready=0: no effect.
//  Async rst mid-frame: immediate return to reset state; partial byte discarded.
//  en_rx stuck 0: FSM frozen, outputs hold.
// TESTING (en_rx every 4 clk, i.e. bit = 64 clk)
//  1 Frame 0x55, stop=1 -> data=0x55, ready=1, frame_err=0 one clk after stop tick 9.
//  2 Low pulse of 3 ticks on idle line -> FSM back to IDLE, ready stays 0, busy drops.
//  3 Frame 0xA3 with stop=0, line held low 40 bits -> data=0xA3, frame_err=1;
//     no second frame until line high; next 0x01 received cleanly.
//  4 Two frames 0x12, 0x34, no rd -> data=0x34, ready=1, overrun=1; rd -> ready=0, overrun=0.
//  5 rd asserted on exact commit clk of 0x7E -> ready=1, overrun=0, data=0x7E.
//  6 rst pulsed mid-DATA of 0xFF, then frame 0x0F -> all outputs 0 after rst; then data=0x0F.

Source files
------------

// File: rtl/uart_rx_core_if.sv
// Bus between the UART receive core and its surroundings: baud tick, pad input,
// CPU read strobe and the received-byte status the register block reads.
interface uart_rx_core_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 en_rx;
    logic                 rxd;
    logic                 rd;
    logic [DATA_BITS-1:0] data;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output en_rx, rxd, rd,
        input  data, ready, frame_err, overrun, busy
    );

    modport slave (
        input  en_rx, rxd, rd,
        output data, ready, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receive core: 16x-oversampled 8N1 deserialiser with majority-voted bits,
// start-glitch rejection, framing/overrun flags and a one-byte holding register.
module uart_rx_core #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic          clk,
    input logic          rst,
    uart_rx_core_if.slave bus
);
    localparam logic [3:0] TickLast = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TickVote = 4'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0] TickS0   = TickVote - 4'd2;
    localparam logic [3:0] TickS1   = TickVote - 4'd1;
    localparam logic [2:0] BitLast  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBrk} state_e;

    state_e               state_q, state_d;
    logic                 rxd_meta_q, rxd_s_q;
    logic [3:0]           tick_q, tick_d;
    logic [2:0]           bit_q, bit_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 vote;

    // Two-flop synchroniser runs every clock; everything else is en_rx qualified.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= bus.rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s_q) | (samp_q[1] & rxd_s_q);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        samp_d  = samp_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        ready_d = ready_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (bus.rd) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end

        if (bus.en_rx) begin
            if (state_q == StStart || state_q == StData || state_q == StStop) begin
                tick_d = tick_q + 4'd1;
                if (tick_q == TickS0) samp_d[0] = rxd_s_q;
                if (tick_q == TickS1) samp_d[1] = rxd_s_q;
            end

            unique case (state_q)
                StIdle: begin
                    if (!rxd_s_q) begin
                        state_d = StStart;
                        tick_d  = 4'd0;
                    end
                end
                StStart: begin
                    if (tick_q == TickVote && vote) begin
                        state_d = StIdle;
                    end else if (tick_q == TickLast) begin
                        state_d = StData;
                        bit_d   = 3'd0;
                    end
                end
                StData: begin
                    if (tick_q == TickVote) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    if (tick_q == TickLast) begin
                        if (bit_q == BitLast) state_d = StStop;
                        else bit_d = bit_q + 3'd1;
                    end
                end
                StStop: begin
                    // A read on the commit clock consumed the old byte, so no overrun.
                    if (tick_q == TickVote) begin
                        data_d  = shreg_q;
                        ready_d = 1'b1;
                        ferr_d  = ~vote;
                        ovr_d   = bus.rd ? 1'b0 : (ovr_q | ready_q);
                        state_d = vote ? StIdle : StBrk;
                    end
                end
                StBrk: begin
                    if (rxd_s_q) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tick_q  <= 4'd0;
            bit_q   <= 3'd0;
            samp_q  <= 2'b00;
            shreg_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            samp_q  <= samp_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.ready     = ready_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames plus random frames; a scoreboard queue
// holds expected bytes and a monitor pops one whenever ready rises.
module tb_uart_rx_core;
    localparam int BitClk = 64;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    // Reference model of what the CPU should see.
    logic       m_ready = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_ferr  = 1'b0;
    logic [7:0] m_data  = 8'h00;

    uart_rx_core_if #(.DATA_BITS(8)) bus ();

    uart_rx_core #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.en_rx = 1'b0;
        forever begin
            bus.en_rx = 1'b0;
            repeat (3) @(negedge clk);
            bus.en_rx = 1'b1;
            @(negedge clk);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        bus.rxd = b;
        wait_clk(BitClk);
    endtask

    task automatic send_data(input logic [7:0] b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
    endtask

    task automatic expect_commit(input logic [7:0] b, input logic stop);
        exp_t e;
        e.d  = b;
        e.fe = ~stop;
        e.ov = m_ovr | m_ready;
        if (!m_ready) q.push_back(e);
        m_ready = 1'b1;
        m_ovr   = e.ov;
        m_data  = b;
        m_ferr  = ~stop;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".data"}, {24'd0, bus.data}, {24'd0, m_data});
        check({tag, ".ready"}, {31'd0, bus.ready}, {31'd0, m_ready});
        check({tag, ".frame_err"}, {31'd0, bus.frame_err}, {31'd0, m_ferr});
        check({tag, ".overrun"}, {31'd0, bus.overrun}, {31'd0, m_ovr});
    endtask

    task automatic frame(input logic [7:0] b, input logic stop, input string tag);
        send_data(b);
        expect_commit(b, stop);
        drive_bit(stop);
        check_model(tag);
    endtask

    task automatic do_rd();
        bus.rd = 1'b1;
        wait_clk(1);
        bus.rd  = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Monitor: every rising edge of ready must match the oldest expected byte.
    initial begin
        logic ready_prev;
        exp_t e;
        ready_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ready && !ready_prev) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon.unexpected: got data %0h with no byte expected", bus.data);
                end else begin
                    e = q.pop_front();
                    check("mon.data", {24'd0, bus.data}, {24'd0, e.d});
                    check("mon.frame_err", {31'd0, bus.frame_err}, {31'd0, e.fe});
                    check("mon.overrun", {31'd0, bus.overrun}, {31'd0, e.ov});
                end
            end
            ready_prev = bus.ready;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] b;
        logic stop;
        bus.rxd = 1'b1;
        bus.rd  = 1'b0;
        wait_clk(3);
        #2 rst = 1'b0;
        wait_clk(2);
        check("reset.busy", {31'd0, bus.busy}, 32'd0);
        check_model("reset");

        // 1: clean frame
        frame(8'h55, 1'b1, "t1");
        do_rd();

        // 2: short low glitch on an idle line
        bus.rxd = 1'b0;
        wait_clk(10);
        check("t2.busy_hi", {31'd0, bus.busy}, 32'd1);
        wait_clk(2);
        bus.rxd = 1'b1;
        wait_clk(BitClk);
        check("t2.busy_lo", {31'd0, bus.busy}, 32'd0);
        check("t2.ready", {31'd0, bus.ready}, 32'd0);

        // 3: framing error followed by a long break
        send_data(8'hA3);
        expect_commit(8'hA3, 1'b0);
        bus.rxd = 1'b0;
        wait_clk(BitClk * 40);
        check_model("t3.brk");
        check("t3.busy_brk", {31'd0, bus.busy}, 32'd1);
        bus.rxd = 1'b1;
        wait_clk(BitClk * 2);
        check("t3.busy_idle", {31'd0, bus.busy}, 32'd0);
        do_rd();
        frame(8'h01, 1'b1, "t3.next");
        do_rd();

        // 4: overrun, then read clears it
        frame(8'h12, 1'b1, "t4.a");
        frame(8'h34, 1'b1, "t4.b");
        check("t4.overrun_set", {31'd0, bus.overrun}, 32'd1);
        do_rd();
        wait_clk(1);
        check_model("t4.rd");

        // 5: rd held through the commit clock; commit must win
        send_data(8'h7E);
        expect_commit(8'h7E, 1'b1);
        bus.rxd = 1'b1;
        bus.rd  = 1'b1;
        n = 0;
        while (n < BitClk && !bus.ready) begin
            @(negedge clk);
            n++;
        end
        bus.rd = 1'b0;
        check("t5.ready_seen", {31'd0, bus.ready}, 32'd1);
        wait_clk(BitClk - n);
        check_model("t5");

        // 6: async reset in the middle of a frame
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        #3 rst = 1'b1;
        wait_clk(2);
        #3 rst = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        m_data  = 8'h00;
        wait_clk(1);
        check("t6.busy", {31'd0, bus.busy}, 32'd0);
        check_model("t6.rst");
        wait_clk(BitClk * 6);
        check("t6.idle", {31'd0, bus.busy}, 32'd0);
        frame(8'h0F, 1'b1, "t6.next");

        // Random frames, random stop bit, gaps and reads
        for (int k = 0; k < 12; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            frame(b, stop, "rnd");
            if ($urandom_range(0, 1) == 1) do_rd();
            bus.rxd = 1'b1;
            n = $urandom_range(stop ? 0 : 1, 2);
            wait_clk(BitClk * n);
            if (n > 0) check("rnd.idle", {31'd0, bus.busy}, 32'd0);
        end

        wait_clk(4);
        check("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
